// File: rtl/riscv_pkg.sv
// Shared RV64 decode constants, hazard sequencer state type and decode helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: n/a.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_RW     = 7'b0111011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    // Everything except the U/J formats reads rs1; JALR listed explicitly since it is easy to mistake for JAL.
    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL: uses_rs1 = 1'b0;
            OP_JALR:                  uses_rs1 = 1'b1;
            default:                  uses_rs1 = 1'b1;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        uses_rs2 = (op == OP_R) || (op == OP_RW) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic is_load(input logic [6:0] op);
        is_load = (op == OP_LOAD);
    endfunction

    function automatic logic is_mdu(input logic [6:0] op, input logic [6:0] f7);
        is_mdu = ((op == OP_R) || (op == OP_RW)) && (f7 == F7_MULDIV);
    endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// Per-register pending-write scoreboard; x0 is hardwired clear.
// Latency: set/clear visible on o_busy the cycle after the request.
// Backpressure: none; a set and a clear of the same register resolve to set.
module rv_scoreboard
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_set_vld,
    input  logic [4:0]  i_set_idx,
    input  logic        i_clr_vld,
    input  logic [4:0]  i_clr_idx,
    output logic [31:0] o_busy
);

    logic [31:0] r_busy;
    logic [31:0] w_set;
    logic [31:0] w_clr;

    // Decode set/clear requests into one-hot masks; x0 can never become busy.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_set_vld) w_set[i_set_idx] = 1'b1;
        if (i_clr_vld) w_clr[i_clr_idx] = 1'b1;
        w_set[0] = 1'b0;
    end

    // Apply clear first, then set, so a same-cycle set on the same register wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= (r_busy & ~w_clr) | w_set;
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock/flush sequencer: RAW and MUL/DIV-occupancy stalls plus multi-cycle flush after EX redirect.
// Latency: stall_if/stall_id are combinational; flush_id rises the cycle after ex_redirect.
// Backpressure: stalls hold IF/ID until the hazard clears; a redirect overrides any stall.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [6:0]       id_func7,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             mdu_done,
    input  logic             ex_redirect,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic [31:0]      busy_vec,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [3:0]       r_flush_cnt;
    logic             r_mdu_busy;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [31:0] w_busy;
    logic        w_in_flush;
    logic        w_raw1;
    logic        w_raw2;
    logic        w_mdu_conf;
    logic        w_hazard;
    logic        w_stall;
    logic        w_issue;
    logic        w_id_mdu;
    logic        w_sb_set;

    assign w_in_flush = (r_state == FLUSH);
    assign w_id_mdu   = is_mdu(id_opcode, id_func7);

    // A WB write to the same register this cycle satisfies the read (RF writes on negedge).
    assign w_raw1 = uses_rs1(id_opcode) && (id_rs1 != 5'd0) && w_busy[id_rs1]
                    && !(wb_valid && (wb_rd == id_rs1));
    assign w_raw2 = uses_rs2(id_opcode) && (id_rs2 != 5'd0) && w_busy[id_rs2]
                    && !(wb_valid && (wb_rd == id_rs2));
    assign w_mdu_conf = w_id_mdu && r_mdu_busy && !mdu_done;

    assign w_hazard = id_valid && !w_in_flush && (w_raw1 || w_raw2 || w_mdu_conf);
    assign w_stall  = w_hazard && !ex_redirect;
    assign w_issue  = id_valid && !w_stall && !ex_redirect && !w_in_flush;
    assign w_sb_set = w_issue && (is_load(id_opcode) || w_id_mdu) && (id_rd != 5'd0);

    rv_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .i_set_vld (w_sb_set),
        .i_set_idx (id_rd),
        .i_clr_vld (wb_valid),
        .i_clr_idx (wb_rd),
        .o_busy    (w_busy)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // Next state: a redirect always wins, from any state, and restarts the flush.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (ex_redirect)   w_state_nxt = FLUSH;
                else if (w_hazard) w_state_nxt = STALL;
            end
            STALL: begin
                if (ex_redirect)    w_state_nxt = FLUSH;
                else if (!w_hazard) w_state_nxt = RUN;
            end
            FLUSH: begin
                if (ex_redirect)              w_state_nxt = FLUSH;
                else if (r_flush_cnt == 4'd0) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // Outputs: flush comes straight from the registered state; stalls are zero-latency.
    always_comb begin
        flush_id = 1'b0;
        stall_if = w_stall;
        stall_id = w_stall;
        if (r_state == FLUSH) flush_id = 1'b1;
    end

    // Flush length counter: reloaded on every redirect so overlapping redirects extend the flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               r_flush_cnt <= 4'd0;
        else if (ex_redirect)                  r_flush_cnt <= FLUSH_LOAD;
        else if (w_in_flush && r_flush_cnt != 4'd0) r_flush_cnt <= r_flush_cnt - 4'd1;
    end

    // Single outstanding MUL/DIV: a new issue on the done cycle keeps the unit marked busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       r_mdu_busy <= 1'b0;
        else if (w_issue && w_id_mdu)  r_mdu_busy <= 1'b1;
        else if (mdu_done)             r_mdu_busy <= 1'b0;
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign busy_vec  = w_busy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: abstract model compared every negedge plus hand-computed directed checks.
// Latency: model updates on posedge, combinational outputs compared mid-cycle.
// Backpressure: n/a.
module tb_hazard_ctrl;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [6:0] id_opcode = '0;
    logic [6:0] id_func7 = '0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic [4:0] id_rd = '0;
    logic       wb_valid = 1'b0;
    logic [4:0] wb_rd = '0;
    logic       mdu_done = 1'b0;
    logic       ex_redirect = 1'b0;

    logic        stall_if, stall_id, flush_id;
    logic [31:0] busy_vec;
    logic [31:0] stall_cnt;
    logic        s4_stall_if, s4_stall_id, s4_flush_id;
    logic [31:0] s4_busy_vec;
    logic [3:0]  s4_stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_func7(id_func7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .mdu_done(mdu_done), .ex_redirect(ex_redirect), .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_func7(id_func7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .mdu_done(mdu_done), .ex_redirect(ex_redirect), .stall_if(s4_stall_if), .stall_id(s4_stall_id),
        .flush_id(s4_flush_id), .busy_vec(s4_busy_vec), .stall_cnt(s4_stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_busy [32];
    bit m_mdu = 1'b0;
    int m_rem = 0;   // flush cycles still to come
    int m_cnt = 0;   // unsaturated stall cycle count

    function automatic bit f_rs1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction
    function automatic bit f_rs2(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0111011 || op == 7'b0100011 || op == 7'b1100011;
    endfunction
    function automatic bit f_mdu(input logic [6:0] op, input logic [6:0] f7);
        return (op == 7'b0110011 || op == 7'b0111011) && f7 == 7'b0000001;
    endfunction
    function automatic bit f_pending(input logic [4:0] r);
        return r != 0 && m_busy[r] && !(wb_valid && wb_rd == r);
    endfunction
    function automatic bit m_stall();
        bit h;
        if (!id_valid || m_rem > 0) return 1'b0;
        h = (f_rs1(id_opcode) && f_pending(id_rs1)) || (f_rs2(id_opcode) && f_pending(id_rs2))
            || (f_mdu(id_opcode, id_func7) && m_mdu && !mdu_done);
        return h && !ex_redirect;
    endfunction
    function automatic bit m_issue();
        return id_valid && !m_stall() && !ex_redirect && m_rem == 0;
    endfunction
    function automatic logic [31:0] m_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
            m_mdu <= 1'b0;
            m_rem <= 0;
            m_cnt <= 0;
        end else begin
            if (m_stall()) m_cnt <= m_cnt + 1;
            if (wb_valid) m_busy[wb_rd] <= 1'b0;
            if (m_issue() && (id_opcode == 7'b0000011 || f_mdu(id_opcode, id_func7)) && id_rd != 0)
                m_busy[id_rd] <= 1'b1;
            if (mdu_done) m_mdu <= 1'b0;
            if (m_issue() && f_mdu(id_opcode, id_func7)) m_mdu <= 1'b1;
            if (ex_redirect)    m_rem <= FC;
            else if (m_rem > 0) m_rem <= m_rem - 1;
        end
    end

    always @(negedge clk) begin
        chk("stall_id", 64'(stall_id), 64'(m_stall()));
        chk("stall_if", 64'(stall_if), 64'(m_stall()));
        chk("flush_id", 64'(flush_id), 64'(m_rem > 0));
        chk("busy_vec", 64'(busy_vec), 64'(m_vec()));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        chk("w4_stall_id", 64'(s4_stall_id), 64'(m_stall()));
        chk("w4_stall_if", 64'(s4_stall_if), 64'(m_stall()));
        chk("w4_flush_id", 64'(s4_flush_id), 64'(m_rem > 0));
        chk("w4_busy_vec", 64'(s4_busy_vec), 64'(m_vec()));
        chk("w4_stall_cnt", 64'(s4_stall_cnt), 64'((m_cnt > 15) ? 15 : m_cnt));
    end

    // ---------------- stimulus ----------------
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] RR = 7'b0110011;
    localparam logic [6:0] MD = 7'b0000001;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [6:0] f7,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        id_valid = v; id_opcode = op; id_func7 = f7; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    endtask

    initial begin
        step(); step(); #2;
        chk("rst_busy", 64'(busy_vec), 64'h0);
        chk("rst_stall", 64'(stall_id), 64'h0);
        chk("rst_flush", 64'(flush_id), 64'h0);
        chk("rst_cnt", 64'(stall_cnt), 64'h0);
        rst = 1'b0;
        step();

        // 1: load-use RAW, released by same-cycle WB
        set_id(1, LD, 0, 1, 0, 5); step();
        set_id(1, RR, 0, 5, 7, 6); #2;
        chk("t1_stall", 64'(stall_id), 64'h1);
        chk("t1_busy", 64'(busy_vec), 64'h20);
        step(); #2;
        chk("t1_stall2", 64'(stall_id), 64'h1);
        chk("t1_cnt", 64'(stall_cnt), 64'd1);
        step(); wb_valid = 1; wb_rd = 5; #2;
        chk("t1_bypass", 64'(stall_id), 64'h0);
        chk("t1_cnt2", 64'(stall_cnt), 64'd2);
        step(); wb_valid = 0; id_valid = 0; #2;
        chk("t1_clear", 64'(busy_vec), 64'h0);

        // 2: x0 is never busy
        set_id(1, LD, 0, 1, 0, 0); step();
        set_id(1, RR, 0, 0, 0, 1); #2;
        chk("t2_busy", 64'(busy_vec), 64'h0);
        chk("t2_stall", 64'(stall_id), 64'h0);
        step(); id_valid = 0;

        // 3: one MUL/DIV at a time; issue on the done cycle keeps the unit busy
        set_id(1, RR, MD, 1, 2, 3); step();
        set_id(1, RR, MD, 1, 2, 4); #2;
        chk("t3_stall", 64'(stall_id), 64'h1);
        chk("t3_busy", 64'(busy_vec), 64'h8);
        step(); #2;
        chk("t3_stall2", 64'(stall_id), 64'h1);
        step(); mdu_done = 1; wb_valid = 1; wb_rd = 3; #2;
        chk("t3_done", 64'(stall_id), 64'h0);
        step(); mdu_done = 0; wb_valid = 0; set_id(1, RR, MD, 1, 2, 8); #2;
        chk("t3_still_busy", 64'(stall_id), 64'h1);
        chk("t3_busy2", 64'(busy_vec), 64'h10);
        step(); mdu_done = 1; wb_valid = 1; wb_rd = 4; #2;
        chk("t3_done2", 64'(stall_id), 64'h0);
        step(); id_valid = 0; wb_rd = 8; step();
        mdu_done = 0; wb_valid = 0; #2;
        chk("t3_empty", 64'(busy_vec), 64'h0);

        // 4: redirect beats stall, squashed load never marks rd busy
        set_id(1, LD, 0, 1, 0, 10); step();
        set_id(1, LD, 0, 10, 0, 12); #2;
        chk("t4_stall", 64'(stall_id), 64'h1);
        step(); ex_redirect = 1; #2;
        chk("t4_redir_stall", 64'(stall_id), 64'h0);
        chk("t4_redir_flush", 64'(flush_id), 64'h0);
        step(); ex_redirect = 0; #2;
        chk("t4_flush1", 64'(flush_id), 64'h1);
        chk("t4_nostall", 64'(stall_id), 64'h0);
        chk("t4_busy", 64'(busy_vec), 64'h400);
        step(); #2;
        chk("t4_flush2", 64'(flush_id), 64'h1);
        step(); id_valid = 0; wb_valid = 1; wb_rd = 10; #2;
        chk("t4_flush_end", 64'(flush_id), 64'h0);
        chk("t4_busy2", 64'(busy_vec), 64'h400);
        step(); wb_valid = 0; #2;
        chk("t4_busy3", 64'(busy_vec), 64'h0);

        // 5: second redirect in first flush cycle extends the flush to 3 cycles
        ex_redirect = 1; step(); #2;
        chk("t5_f1", 64'(flush_id), 64'h1);
        step(); ex_redirect = 0; #2;
        chk("t5_f2", 64'(flush_id), 64'h1);
        step(); #2;
        chk("t5_f3", 64'(flush_id), 64'h1);
        step(); #2;
        chk("t5_f4", 64'(flush_id), 64'h0);

        // 6: set beats clear on same register; 4-bit stall counter saturates
        set_id(1, LD, 0, 1, 0, 9); step();
        wb_valid = 1; wb_rd = 9; #2;
        chk("t6_nostall", 64'(stall_id), 64'h0);
        step(); id_valid = 0; wb_valid = 0; #2;
        chk("t6_busy9", 64'(busy_vec), 64'h200);
        step(); wb_valid = 1; wb_rd = 9; step(); wb_valid = 0;
        set_id(1, LD, 0, 1, 0, 13); step();
        set_id(1, RR, 0, 13, 0, 14);
        repeat (20) step();
        #2;
        chk("t6_sat", 64'(s4_stall_cnt), 64'hF);
        id_valid = 0; wb_valid = 1; wb_rd = 13; step(); wb_valid = 0;

        // 7: async reset mid-flush
        set_id(1, LD, 0, 1, 0, 15); step();
        id_valid = 0; ex_redirect = 1; step();
        ex_redirect = 0; #2;
        chk("t7_flush", 64'(flush_id), 64'h1);
        chk("t7_busy", 64'(busy_vec), 64'h8000);
        #1 rst = 1;
        #1;
        chk("t7_rst_flush", 64'(flush_id), 64'h0);
        chk("t7_rst_busy", 64'(busy_vec), 64'h0);
        chk("t7_rst_cnt", 64'(stall_cnt), 64'h0);
        chk("t7_rst_cnt4", 64'(s4_stall_cnt), 64'h0);
        step(); step(); rst = 0; #2;
        chk("t7_after", 64'(flush_id), 64'h0);
        step(); #2;
        chk("t7_after2", 64'(flush_id), 64'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
